round_timer_ctrl: RTL and testbench

- Controller at the driving end of the minute countdown timer interface.
- Sequences a 60 s game round: issues timer clear and count-enable, watches the returned tens/ones BCD digits, and detects expiry at 00.
- Reports round status to the top level: running, paused, game over and a low-time warning.
- Sits between the debounced button logic and the countdown timer, in the system clock domain.

---
 rtl/round_timer_ctrl_pkg.sv | 21 ++
 rtl/round_warn_gen.sv | 47 ++++
 rtl/round_timer_ctrl.sv | 131 +++++++++++++
 tb/tb_round_timer_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/round_timer_ctrl_pkg.sv
// Shared types and constants for the round timer controller.
package round_timer_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } round_state_e;

  localparam int MAX_TENS    = 6;
  localparam int MAX_ONES    = 9;
  localparam int DIGIT_W_DEF = 4;

  // A round is "in progress" while counting or paused.
  function automatic logic in_round(input round_state_e s);
    return (s == ST_RUN) || (s == ST_PAUSE);
  endfunction

endpackage

// File: rtl/round_warn_gen.sv
// Low-time warning output stage. Define WARN_BLINK_EN to blink warn on each
// tick while the warning condition holds; otherwise warn is a steady level.
module round_warn_gen (
  input  logic clk,
  input  logic clr,
  input  logic cond,
  input  logic tick,
  input  logic hold,
  output logic warn
);

`ifdef WARN_BLINK_EN
  logic cond_r;

  // Blink: start high on entry, toggle per tick, freeze while held.
  always_ff @(posedge clk) begin
    if (clr) begin
      cond_r <= 1'b0;
      warn   <= 1'b0;
    end else begin
      cond_r <= cond;
      if (!cond) begin
        warn <= 1'b0;
      end else if (!cond_r) begin
        warn <= 1'b1;
      end else if (tick && !hold) begin
        warn <= ~warn;
      end else begin
        warn <= warn;
      end
    end
  end
`else
  logic unused_ok_s;
  assign unused_ok_s = tick ^ hold;

  // Steady warning level.
  always_ff @(posedge clk) begin
    if (clr) begin
      warn <= 1'b0;
    end else begin
      warn <= cond;
    end
  end
`endif

endmodule

// File: rtl/round_timer_ctrl.sv
// Round sequencer driving the minute countdown timer; detects expiry at 00.
// Optional WARN_BLINK_EN makes the low-time warning blink (see round_warn_gen).
module round_timer_ctrl
  import round_timer_ctrl_pkg::*;
#(
  parameter int DIGIT_W   = DIGIT_W_DEF,
  parameter int WARN_TENS = 0
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               pause,
  input  logic               tick,
  input  logic [DIGIT_W-1:0] tens,
  input  logic [DIGIT_W-1:0] ones,
  output logic               timer_clr,
  output logic               timer_cnt,
  output logic               running,
  output logic               paused,
  output logic               game_over,
  output logic               done_pulse,
  output logic               warn
);

  localparam logic [DIGIT_W-1:0] WARN_TENS_L = DIGIT_W'(WARN_TENS);
  localparam logic [DIGIT_W-1:0] DIGIT_ZERO  = '0;

  round_state_e state_r;
  round_state_e nxt_state_s;
  logic         armed_r;
  logic         nxt_armed_s;
  logic         zero_s;
  logic         warn_cond_s;
  logic         warn_hold_s;

  assign zero_s = (tens == DIGIT_ZERO) && (ones == DIGIT_ZERO);

  // Next-state and armed-flag decode; start outranks pause everywhere.
  always_comb begin
    nxt_state_s = state_r;
    nxt_armed_s = armed_r;
    case (state_r)
      ST_IDLE: begin
        if (start) nxt_state_s = ST_LOAD;
        else       nxt_state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (tick) begin
          nxt_state_s = ST_RUN;
          nxt_armed_s = 1'b0;
        end else begin
          nxt_state_s = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (start) begin
          nxt_state_s = ST_LOAD;
          nxt_armed_s = 1'b0;
        end else if (pause) begin
          nxt_state_s = ST_PAUSE;
        end else if (armed_r && zero_s) begin
          // Digits read 00 straight after a clear, so only trust them once armed.
          nxt_state_s = ST_DONE;
        end else if (tick) begin
          nxt_armed_s = 1'b1;
        end else begin
          nxt_state_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (start) begin
          nxt_state_s = ST_LOAD;
          nxt_armed_s = 1'b0;
        end else if (pause) begin
          nxt_state_s = ST_RUN;
        end else begin
          nxt_state_s = ST_PAUSE;
        end
      end
      ST_DONE: begin
        if (start) begin
          nxt_state_s = ST_LOAD;
          nxt_armed_s = 1'b0;
        end else begin
          nxt_state_s = ST_DONE;
        end
      end
      default: begin
        nxt_state_s = ST_IDLE;
        nxt_armed_s = 1'b0;
      end
    endcase
  end

  // Warning is judged on the upcoming state so it lines up with the other outputs.
  assign warn_cond_s = in_round(nxt_state_s) && nxt_armed_s && (tens <= WARN_TENS_L);
  assign warn_hold_s = (state_r == ST_PAUSE);

  // State register and registered status outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r    <= ST_IDLE;
      armed_r    <= 1'b0;
      timer_clr  <= 1'b1;
      timer_cnt  <= 1'b0;
      running    <= 1'b0;
      paused     <= 1'b0;
      game_over  <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state_r    <= nxt_state_s;
      armed_r    <= nxt_armed_s;
      timer_clr  <= (nxt_state_s == ST_IDLE) || (nxt_state_s == ST_LOAD);
      timer_cnt  <= (nxt_state_s == ST_RUN);
      running    <= (nxt_state_s == ST_RUN);
      paused     <= (nxt_state_s == ST_PAUSE);
      game_over  <= (nxt_state_s == ST_DONE);
      done_pulse <= (nxt_state_s == ST_DONE) && (state_r != ST_DONE);
    end
  end

  round_warn_gen u_warn_gen (
    .clk  (clk),
    .clr  (clr),
    .cond (warn_cond_s),
    .tick (tick),
    .hold (warn_hold_s),
    .warn (warn)
  );

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Scoreboard bench for round_timer_ctrl: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_round_timer_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] tens = 4'd0;
  logic [3:0] ones = 4'd0;
  logic       timer_clr, timer_cnt, running, paused, game_over, done_pulse, warn;

  round_timer_ctrl #(.DIGIT_W(4), .WARN_TENS(0)) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .pause      (pause),
    .tick       (tick),
    .tens       (tens),
    .ones       (ones),
    .timer_clr  (timer_clr),
    .timer_cnt  (timer_cnt),
    .running    (running),
    .paused     (paused),
    .game_over  (game_over),
    .done_pulse (done_pulse),
    .warn       (warn)
  );

  always #5 clk = ~clk;

  // Output vector: {timer_clr, timer_cnt, running, paused, game_over, done_pulse, warn}
  localparam logic [6:0] O_IDLE  = 7'b1000000;
  localparam logic [6:0] O_RUN   = 7'b0110000;
  localparam logic [6:0] O_PAUSE = 7'b0001000;
  localparam logic [6:0] O_DONE1 = 7'b0000110;
  localparam logic [6:0] O_DONE  = 7'b0000100;

  typedef struct {
    int         at;
    logic [6:0] vec;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic [6:0] obs;

  assign obs = {timer_clr, timer_cnt, running, paused, game_over, done_pulse, warn};

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      checks = checks + 1;
      if (e.at != cyc || obs !== e.vec) begin
        errors = errors + 1;
        $display("FAIL %s cycle %0d: got %b expected %b", e.name, cyc, obs, e.vec);
      end
    end
  end

  task automatic drive(input logic c, input logic s, input logic p, input logic t,
                       input int tn, input int on);
    @(posedge clk);
    #1;
    clr   = c;
    start = s;
    pause = p;
    tick  = t;
    tens  = 4'(tn);
    ones  = 4'(on);
  endtask

  task automatic expect_o(input string n, input logic [6:0] v);
    sb_q.push_back('{cyc + 1, v, n});
  endtask

  function automatic logic exp_warn(input int o);
`ifdef WARN_BLINK_EN
    return ((9 - o) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] v;
    // reset then idle
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0); expect_o("rst0", O_IDLE);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0); expect_o("rst1", O_IDLE);
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0); expect_o("idle", O_IDLE);
    end

    // full round with arm suppression
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0); expect_o("load", O_IDLE);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0); expect_o("load_hold", O_IDLE);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0); expect_o("load_start_ign", O_IDLE);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0); expect_o("run_enter", O_RUN);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0); expect_o("arm_suppress", O_RUN);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0); expect_o("arm_suppress2", O_RUN);
    for (int n = 59; n >= 1; n--) begin
      v = O_RUN;
      if (n / 10 == 0) v[0] = exp_warn(n % 10);
      drive(1'b0, 1'b0, 1'b0, 1'b1, n / 10, n % 10); expect_o("count_tick", v);
      drive(1'b0, 1'b0, 1'b0, 1'b0, n / 10, n % 10); expect_o("count_hold", v);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0); expect_o("done_entry", O_DONE1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0); expect_o("done_hold", O_DONE);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0); expect_o("done_pause_ign", O_DONE);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0); expect_o("done_tick_ign", O_DONE);

    // pause handling and start-over-pause priority
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0); expect_o("restart_load", O_IDLE);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0); expect_o("run2", O_RUN);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5, 9); expect_o("arm2", O_RUN);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3, 2); expect_o("at32", O_RUN);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3, 2); expect_o("pause_on", O_PAUSE);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 3, 2); expect_o("pause_tick", O_PAUSE);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3, 2); expect_o("pause_off", O_RUN);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3, 2); expect_o("start_beats_pause", O_IDLE);

    // warning threshold and warn while paused
    drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0); expect_o("run3", O_RUN);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5, 9); expect_o("arm3", O_RUN);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1, 0); expect_o("warn_10", O_RUN);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 9); expect_o("warn_09", O_RUN | 7'b0000001);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 9); expect_o("warn_pause", O_PAUSE | 7'b0000001);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 9); expect_o("warn_pause_tick", O_PAUSE | 7'b0000001);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 9); expect_o("pause_restart", O_IDLE);

    // mid-round reset
    drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0); expect_o("run4", O_RUN);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5, 9); expect_o("arm4", O_RUN);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2, 5); expect_o("at25", O_RUN);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2, 5); expect_o("mid_reset", O_IDLE);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0); expect_o("post_reset_idle", O_IDLE);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0); expect_o("post_reset_idle2", O_IDLE);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0); expect_o("load5", O_IDLE);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0); expect_o("run5", O_RUN);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0); expect_o("armed_cleared", O_RUN);

    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
